// File: rtl/reg_file_alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_alu_pipe_if
// Brief    : Instruction/result bundle between an issuer and reg_file_alu_pipe.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_file_alu_pipe_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic [ADDR_W-1:0] RA1;
  logic [ADDR_W-1:0] RA2;
  logic [ADDR_W-1:0] WA;
  logic [DATA_W-1:0] external_data_in;
  logic              RegWrite;
  logic              ALUSrc;
  logic              WBSel;
  logic [2:0]        ALUControl;
  logic              out_valid;
  logic [DATA_W-1:0] ALUResult;
  logic              Zero;
  logic              Carry;

  modport master (
    output in_valid, RA1, RA2, WA, external_data_in, RegWrite, ALUSrc, WBSel, ALUControl,
    input  out_valid, ALUResult, Zero, Carry
  );

  modport slave (
    input  in_valid, RA1, RA2, WA, external_data_in, RegWrite, ALUSrc, WBSel, ALUControl,
    output out_valid, ALUResult, Zero, Carry
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_alu_pipe
// Brief    : Two-stage register-file/ALU execute core with write-back bypass.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_alu_pipe #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  wire logic           clk,
  input  wire logic           reset,
  reg_file_alu_pipe_if.slave  bus
);
  localparam int         c_num_regs  = 2 ** ADDR_W;
  localparam bit         c_zero_reg  = (ZERO_REG != 0);
  localparam logic [2:0] c_op_passb  = 3'b000;
  localparam logic [2:0] c_op_passa  = 3'b001;
  localparam logic [2:0] c_op_add    = 3'b010;
  localparam logic [2:0] c_op_sub    = 3'b011;
  localparam logic [2:0] c_op_and    = 3'b100;
  localparam logic [2:0] c_op_or     = 3'b101;
  localparam logic [2:0] c_op_xor    = 3'b110;
  localparam logic [2:0] c_op_sltu   = 3'b111;

  logic [DATA_W-1:0] r_regs [c_num_regs];

  logic              r_s1_valid;
  logic              r_s1_reg_write;
  logic              r_s1_wb_sel;
  logic [ADDR_W-1:0] r_s1_wa;
  logic [2:0]        r_s1_ctrl;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic [DATA_W-1:0] r_s1_ext;

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_carry;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  assign w_sum     = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_diff    = {1'b0, r_s1_a} - {1'b0, r_s1_b};
  assign w_wb_data = r_s1_wb_sel ? r_s1_ext : w_alu_res;
  // Writes to r0 are suppressed here, which also keeps them out of the bypass.
  assign w_wr_en   = r_s1_valid && r_s1_reg_write && !(c_zero_reg && (r_s1_wa == '0));

  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    case (r_s1_ctrl)
      c_op_passb: w_alu_res = r_s1_b;
      c_op_passa: w_alu_res = r_s1_a;
      c_op_add: begin
        w_alu_res   = w_sum[DATA_W-1:0];
        w_alu_carry = w_sum[DATA_W];
      end
      c_op_sub: begin
        w_alu_res   = w_diff[DATA_W-1:0];
        w_alu_carry = w_diff[DATA_W];
      end
      c_op_and:  w_alu_res = r_s1_a & r_s1_b;
      c_op_or:   w_alu_res = r_s1_a | r_s1_b;
      c_op_xor:  w_alu_res = r_s1_a ^ r_s1_b;
      c_op_sltu: w_alu_res = {{(DATA_W-1){1'b0}}, w_diff[DATA_W]};
      default:   w_alu_res = '0;
    endcase
  end

  // The write for the instruction in stage 2 lands on the same edge that
  // captures the next one, so its data must be bypassed to the read ports.
  always_comb begin
    w_rd_a = r_regs[bus.RA1];
    if (c_zero_reg && (bus.RA1 == '0)) begin
      w_rd_a = '0;
    end else if (w_wr_en && (r_s1_wa == bus.RA1)) begin
      w_rd_a = w_wb_data;
    end
  end

  always_comb begin
    w_rd_b = r_regs[bus.RA2];
    if (c_zero_reg && (bus.RA2 == '0)) begin
      w_rd_b = '0;
    end else if (w_wr_en && (r_s1_wa == bus.RA2)) begin
      w_rd_b = w_wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid     <= 1'b0;
      r_s1_reg_write <= 1'b0;
      r_s1_wb_sel    <= 1'b0;
      r_s1_wa        <= '0;
      r_s1_ctrl      <= '0;
      r_s1_a         <= '0;
      r_s1_b         <= '0;
      r_s1_ext       <= '0;
      bus.out_valid  <= 1'b0;
      bus.ALUResult  <= '0;
      bus.Zero       <= 1'b0;
      bus.Carry      <= 1'b0;
    end else begin
      r_s1_valid    <= bus.in_valid;
      bus.out_valid <= r_s1_valid;
      if (bus.in_valid) begin
        r_s1_reg_write <= bus.RegWrite;
        r_s1_wb_sel    <= bus.WBSel;
        r_s1_wa        <= bus.WA;
        r_s1_ctrl      <= bus.ALUControl;
        r_s1_a         <= w_rd_a;
        r_s1_b         <= bus.ALUSrc ? bus.external_data_in : w_rd_b;
        r_s1_ext       <= bus.external_data_in;
      end
      if (r_s1_valid) begin
        bus.ALUResult <= w_alu_res;
        bus.Zero      <= (w_alu_res == '0);
        bus.Carry     <= w_alu_carry;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_num_regs; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[r_s1_wa] <= w_wb_data;
    end
  end
endmodule
`default_nettype wire

// File: doc/reg_file_alu_pipe.md
Name: reg_file_alu_pipe

Overview:
Parametrised successor to the single-cycle register-file/ALU datapath. It pairs a 2^ADDR_W x DATA_W register file with an 8-operation ALU and adds the following:
- a registered execute stage
- ALU-result write-back into the register file
- operand forwarding
- a valid handshake
- Zero and Carry flags
It is the execute/write-back core for the team's small CPU datapath.

Parameters:
DATA_W, 8, register and ALU data width in bits
ADDR_W, 4, register address width; the file holds 2^ADDR_W registers
ZERO_REG, 1, when 1, register 0 always reads 0 and writes to it are discarded

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; 0 = reset asserted
in_valid  input  1  an instruction is presented this cycle
RA1  input  ADDR_W  read address for operand A
RA2  input  ADDR_W  read address for operand B
WA  input  ADDR_W  write-back address
external_data_in  input  DATA_W  immediate / external data
RegWrite  input  1  the instruction writes back to WA
ALUSrc  input  1  1: operand B = external_data_in; 0: operand B = reg[RA2]
WBSel  input  1  1: write-back data = external_data_in; 0: write-back data = ALU result
ALUControl  input  3  operation select
out_valid  output  1  ALUResult/Zero/Carry hold a new result
ALUResult  output  DATA_W  registered ALU result
Zero  output  1  registered; 1 when the result is 0
Carry  output  1  registered carry/borrow

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers, pipeline state, out_valid, ALUResult, Zero and Carry go to 0 immediately.
  - An in-flight instruction is dropped and performs no write.
  - The first instruction after reset=1 is sampled at the first rising edge with reset high.
- Stage 1 (issue), at rising edge E with in_valid=1:
  - operands A and B are read combinationally and captured.
  - RA1, RA2, WA, RegWrite, WBSel, ALUControl and external_data_in are captured with them.
- Stage 2 (execute/write-back), at edge E+1:
  - ALUResult, Zero, Carry are registered and out_valid=1 is asserted.
  - If RegWrite=1, reg[WA] is written at the same edge.
  - Latency: a result is visible after exactly one edge following capture. Throughput: one instruction per cycle.
- Bubble (in_valid=0 at E): out_valid=0 after E+1, no register write, and ALUResult/Zero/Carry hold their previous values.
- ALUControl, width DATA_W, wraps modulo 2^DATA_W:
  - 000 PASSB: B
  - 001 PASSA: A
  - 010 ADD: A+B; Carry = carry-out
  - 011 SUB: A-B; Carry = 1 when A<B unsigned (borrow)
  - 100 AND
  - 101 OR
  - 110 XOR
  - 111 SLTU: result 1 if A<B unsigned, else 0
- Carry is 0 for all ops except ADD and SUB. Zero = (ALUResult == 0) for every op.
- Forwarding:
  - Applies when stage 2 holds a valid instruction with RegWrite=1 and WA equal to the stage-1 RA1 (or RA2).
  - The stage-1 read then returns that instruction's write-back data instead of the stale register.
  - This is a combinational bypass, so back-to-back dependent instructions need no stall.
  - It does not apply when the address is 0 and ZERO_REG=1.
- Register 0 (ZERO_REG=1): reads of address 0 return 0; writes to 0 are discarded and never forwarded.
- Simultaneous RA1=RA2=WA in one instruction: reads return the pre-write (or forwarded) value; the write takes effect at E+1.
- No back-pressure: the consumer must accept each out_valid pulse in the cycle it occurs.

Test Plan:
All scenarios use default parameters.
- Reset: hold reset=0 mid-clock -> ALUResult=0, Zero=0, Carry=0, out_valid=0 immediately; then PASSA of every register reads 0.
- Load + ADD: PASSB with ALUSrc=1, RegWrite=1, WBSel=0:
  - write r5=5, then r4=4 back-to-back;
  - then ADD RA1=5, RA2=4 -> ALUResult=9, Zero=0, Carry=0, out_valid=1 one edge after issue.
- SUB/flags:
  - SUB r4-r5 -> ALUResult=0xFF, Carry=1.
  - SUB r5-r5 -> 0x00, Zero=1, Carry=0.
  - SLTU r4,r5 -> 0x01.
- Forwarding: write r3=0x80, then on the very next cycle ADD RA1=3, RA2=3 -> ALUResult=0x00, Carry=1, Zero=1 (no stale 0 used).
- r0 and bubbles:
  - write 0x07 to WA=0, then PASSA RA1=0 -> 0x00.
  - An in_valid=0 cycle gives out_valid=0 with ALUResult held at its prior value.
- Reset mid-operation: issue write r6=0x55 and pull reset low before the next edge -> no write; after release, PASSA r6 -> 0x00.
